// File: rtl/mux_n_1_rr_reg_pkg.sv
// Shared definitions for the registered N:1 multiplexer with fixed or round-robin select.
package mux_n_1_rr_reg_pkg;

  typedef enum logic {
    MuxModeFixed = 1'b0,
    MuxModeRr    = 1'b1
  } mux_mode_e;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultNumIn = 4;

endpackage

// File: rtl/mux_n_1_rr_reg_if.sv
// Input channels, select controls and registered output handshake of mux_n_1_rr_reg.
interface mux_n_1_rr_reg_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SELW  = $clog2(NUM_IN)
);
  logic                    mode;
  logic [SELW-1:0]         sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SELW-1:0]         out_src;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_n_1_rr_reg_rr_pick.sv
// Rotating priority encoder: first asserted req after ptr, wrapping modulo NUM_IN.
module rr_pick #(
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SELW  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SELW-1:0]   ptr,
  output logic [SELW-1:0]   gnt_idx,
  output logic              gnt_any
);
  int unsigned cand;

  // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int unsigned k = NUM_IN; k >= 1; k--) begin
      cand = (32'(ptr) + k) % NUM_IN;
      if (req[SELW'(cand)]) begin
        gnt_idx = SELW'(cand);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_n_1_rr_reg.sv
// N:1 multiplexer with fixed or round-robin grant and a registered valid/ready output stage.
module mux_n_1_rr_reg
  import mux_n_1_rr_reg_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned NUM_IN = DefaultNumIn,
  localparam int unsigned SELW  = $clog2(NUM_IN)
) (
  input logic             clk,
  input logic             reset,
  mux_n_1_rr_reg_if.slave bus
);
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;

  logic [SELW-1:0]  rr_idx, gnt_idx;
  logic             rr_any, fix_any, gnt_any;
  logic             load_en;
  logic [WIDTH-1:0] gnt_data;

  rr_pick #(
    .NUM_IN (NUM_IN)
  ) u_rr_pick (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign load_en = ~out_valid_q | bus.out_ready;

  // An out-of-range sel matches no channel and therefore never grants.
  always_comb begin
    fix_any = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SELW'(i) && bus.in_valid[i]) fix_any = 1'b1;
    end
  end

  assign gnt_idx = (bus.mode == MuxModeRr) ? rr_idx : bus.sel;
  assign gnt_any = (bus.mode == MuxModeRr) ? rr_any : fix_any;

  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SELW'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
      bus.in_ready[i] = ~reset & load_en & gnt_any & (gnt_idx == SELW'(i));
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    if (load_en) begin
      if (gnt_any) begin
        out_data_d  = gnt_data;
        out_src_d   = gnt_idx;
        out_valid_d = 1'b1;
        if (bus.mode == MuxModeRr) rr_ptr_d = gnt_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= SELW'(NUM_IN - 1);
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
endmodule
